uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 8, data width per received character.
REQ-002 SHALL have parameter DEPTH, default 16, number of entries; power of two, minimum 2.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic is on the rising edge.
REQ-004 SHALL have port reset  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  one-cycle pulse: character received (from the UART receiver valid output).
REQ-006 SHALL have port in_data  input  PAYLOAD_BITS  received character, qualified by in_valid.
REQ-007 SHALL have port in_break  input  1  BREAK indication, qualified by in_valid.
REQ-008 SHALL have port out_valid  output  1  head entry available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-010 SHALL have port out_data  output  PAYLOAD_BITS  head entry data.
REQ-011 SHALL have port out_break  output  1  head entry BREAK flag (see REQ-031).
REQ-012 SHALL have port level  output  log2(DEPTH)+1  current occupancy.
REQ-013 SHALL have ports full and empty  output  1 each  occupancy == DEPTH and occupancy == 0.
REQ-014 SHALL have port overflow  output  1  sticky flag: a character was dropped.
REQ-015 SHALL have port overflow_clr  input  1  clears overflow.

Function
REQ-016 SHALL push {in_break, in_data} on a cycle where in_valid=1 and (full=0 or a pop occurs the same cycle).
REQ-017 SHALL pop on a cycle where out_valid=1 and out_ready=1; out_ready SHALL be ignored while out_valid=0.
REQ-018 SHALL drive out_valid = !empty; out_data/out_break SHALL present the oldest entry, first-word fall-through.
REQ-019 SHALL make a character pushed at edge N visible on out_valid/out_data from edge N onward (one-cycle latency from the in_valid cycle).
REQ-020 SHALL keep out_data/out_break stable while out_valid=1 and out_ready=0.
REQ-021 SHALL use read/write pointers of log2(DEPTH)+1 bits that wrap modulo 2*DEPTH; full/empty SHALL derive from pointer MSB/LSB comparison, and level = wr_ptr - rd_ptr (modulo arithmetic).
REQ-022 SHALL, on simultaneous push and pop, leave level unchanged; when empty, a simultaneous push SHALL NOT pop (no bypass).
REQ-023 SHALL, when full and not popping, drop an in_valid character, leave contents and pointers unchanged, and set overflow at the next edge.
REQ-024 SHALL hold overflow until overflow_clr=1; on the same cycle, a new drop SHALL win over clear (overflow stays 1).
REQ-025 SHALL register level, full, empty and overflow (no combinational path from in_valid/out_ready to them).

Reset
REQ-026 SHALL, with reset=1 at a clock edge, set pointers to 0, level=0, empty=1, full=0, out_valid=0, overflow=0; out_data and out_break SHALL read 0 while empty.
REQ-027 SHALL, on reset asserted mid-operation, discard all stored entries and ignore in_valid and out_ready in that cycle.
REQ-028 SHALL NOT require reset of the storage array contents.

Configuration
REQ-029 SHALL use macro UART_RX_FIFO_BREAK_EN to control BREAK storage.
REQ-030 SHALL, with the macro undefined, store only in_data, tie out_break to 0, and silently discard characters with in_break=1 (no push, no overflow).
REQ-031 SHALL, with the macro defined, store in_break with each entry (PAYLOAD_BITS+1 wide) and present it on out_break.

Structure
REQ-032 SHALL take PAYLOAD_BITS, the default DEPTH and the pointer-width function from shared package uart_pkg, also used by the UART receiver and transmitter.
REQ-033 SHALL instantiate one sub-module uart_fifo_mem: a simple dual-port register array, with synchronous write and asynchronous read, parameterised by width and depth.

Verification
REQ-034 SHALL check reset: after reset, empty=1, level=0, out_valid=0, overflow=0; an in_valid in the reset cycle is not stored.
REQ-035 SHALL check ordering: push 0x41,0x42,0x43 with out_ready=0 -> level=3; then out_ready=1 -> out_data 0x41,0x42,0x43 on consecutive cycles, then empty=1.
REQ-036 SHALL check overflow: push 17 characters into DEPTH=16 with no pops -> full=1, level=16, overflow=1, 17th lost; pop 16 -> first 16 values only; overflow_clr -> overflow=0.
REQ-037 SHALL check simultaneous push/pop when full: push 0xAA while out_ready=1 -> level stays 16, 0xAA becomes last entry, overflow stays 0.
REQ-038 SHALL check wrap-around: 40 push/pop pairs with pseudo-random data and 0-3-cycle gaps -> output matches a reference queue, pointers wrap with no loss.
REQ-039 SHALL check BREAK in_valid with in_data=0x00, in_break=1 -> macro defined: out_break=1, out_data=0x00; macro undefined: nothing stored, level unchanged.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants and helpers for the receiver, transmitter and RX FIFO.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

  localparam int UART_PAYLOAD_BITS = 8;
  localparam int UART_FIFO_DEPTH   = 16;

  // Pointer width carries one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Write lands at the clock edge, read is combinational; no flow control of its own.
module uart_fifo_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART RX character FIFO, first-word fall-through; entry visible one edge after in_valid.
// Full with no pop drops the character and sets sticky overflow; BREAK storage via UART_RX_FIFO_BREAK_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int PAYLOAD_BITS = UART_PAYLOAD_BITS,
  parameter int DEPTH        = UART_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [PAYLOAD_BITS-1:0]      in_data,
  input  logic                         in_break,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PAYLOAD_BITS-1:0]      out_data,
  output logic                         out_break,
  output logic [ptr_width(DEPTH)-1:0]  level,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow,
  input  logic                         overflow_clr
);

  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

`ifdef UART_RX_FIFO_BREAK_EN
  localparam int EW = PAYLOAD_BITS + 1;
`else
  localparam int EW = PAYLOAD_BITS;
`endif

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [EW-1:0] wr_entry, rd_entry;
  logic          storable, push, pop, drop;

`ifdef UART_RX_FIFO_BREAK_EN
  assign storable = in_valid;
  assign wr_entry = {in_break, in_data};
`else
  // Without BREAK storage a BREAK character is not data: discard it silently.
  assign storable = in_valid & ~in_break;
  assign wr_entry = in_data;
`endif

  assign pop        = ~empty & out_ready;
  assign push       = storable & (~full | pop);
  assign drop       = storable & full & ~pop;
  assign wr_ptr_nxt = wr_ptr + PW'(push);
  assign rd_ptr_nxt = rd_ptr + PW'(pop);

  // Status is computed from next-state pointers so every flag is a flop output.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      level    <= wr_ptr_nxt - rd_ptr_nxt;
      empty    <= (wr_ptr_nxt == rd_ptr_nxt);
      full     <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                  (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
      overflow <= drop | (overflow & ~overflow_clr);
    end
  end

  uart_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push & ~reset),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (wr_entry),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (rd_entry)
  );

  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : rd_entry[PAYLOAD_BITS-1:0];

`ifdef UART_RX_FIFO_BREAK_EN
  assign out_break = ~empty & rd_entry[PAYLOAD_BITS];
`else
  assign out_break = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table plus sequences for reset, overflow and wrap-around.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_break;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_break;
  logic [4:0] level;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       overflow_clr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .PAYLOAD_BITS (8),
    .DEPTH        (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_break     (in_break),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_break    (out_break),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ib;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic       eb;
    logic [4:0] el;
    logic       ef;
    logic       ee;
    logic       eo;
  } vec_t;

  vec_t       vt[$];
  logic [7:0] q[$];

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ib,
                              input logic rdy, input logic clr, input logic ev,
                              input logic [7:0] ed, input logic eb, input logic [4:0] el,
                              input logic ef, input logic ee, input logic eo);
    vec_t v;
    v.iv = iv; v.id = id; v.ib = ib; v.rdy = rdy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.eb = eb; v.el = el; v.ef = ef; v.ee = ee; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled at the same point.
  task automatic drive(input logic iv, input logic [7:0] id, input logic ib,
                       input logic rdy, input logic clr);
    in_valid = iv; in_data = id; in_break = ib; out_ready = rdy; overflow_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h55; in_break = 1'b0;
    out_ready = 1'b1; overflow_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_full", full, 0);
    chk("rst_data", out_data, 0);
    idle();
    chk("rst_nostore_empty", empty, 1);

    // iv id ib rdy clr | valid data brk level full empty ovf
    vt.push_back(mk(1, 8'h41, 0, 0, 0, 1, 8'h41, 0, 1, 0, 0, 0));
    vt.push_back(mk(1, 8'h42, 0, 0, 0, 1, 8'h41, 0, 2, 0, 0, 0));
    vt.push_back(mk(1, 8'h43, 0, 0, 0, 1, 8'h41, 0, 3, 0, 0, 0));
    vt.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'h41, 0, 3, 0, 0, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 1, 8'h42, 0, 2, 0, 0, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 1, 8'h43, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 8'h44, 0, 1, 0, 1, 8'h44, 0, 1, 0, 0, 0));
    vt.push_back(mk(1, 8'h45, 0, 1, 0, 1, 8'h45, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 1, 0));
`ifdef UART_RX_FIFO_BREAK_EN
    vt.push_back(mk(1, 8'h00, 1, 0, 0, 1, 8'h00, 1, 1, 0, 0, 0));
`else
    vt.push_back(mk(1, 8'h00, 1, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0));
`endif
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 1, 0));
    vt.push_back(mk(1, 8'h5A, 0, 0, 1, 1, 8'h5A, 0, 1, 0, 0, 0));
    vt.push_back(mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0, 0, 1, 0));

    foreach (vt[i]) begin
      drive(vt[i].iv, vt[i].id, vt[i].ib, vt[i].rdy, vt[i].clr);
      chk($sformatf("row%0d_valid", i), out_valid, vt[i].ev);
      chk($sformatf("row%0d_data", i),  out_data,  vt[i].ed);
      chk($sformatf("row%0d_break", i), out_break, vt[i].eb);
      chk($sformatf("row%0d_level", i), level,     vt[i].el);
      chk($sformatf("row%0d_full", i),  full,      vt[i].ef);
      chk($sformatf("row%0d_empty", i), empty,     vt[i].ee);
      chk($sformatf("row%0d_ovf", i),   overflow,  vt[i].eo);
    end

    // Reset mid-operation discards contents and ignores that cycle's handshakes.
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("midrst_pre_level", level, 3);
    reset = 1'b1;
    drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    chk("midrst_level", level, 0);
    chk("midrst_empty", empty, 1);
    idle();
    chk("midrst_after_empty", empty, 1);

    // Fill past capacity: 17th character lost, overflow set.
    for (int i = 0; i < 16; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill16_full", full, 1);
    chk("fill16_level", level, 16);
    chk("fill16_ovf", overflow, 0);
    drive(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_level", level, 16);
    chk("ovf_full", full, 1);
    drive(1'b1, 8'h99, 1'b0, 1'b0, 1'b1);
    chk("ovf_drop_beats_clr", overflow, 1);
    chk("ovf_drop_level", level, 16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_pop%0d", i), out_data, 8'h10 + 8'(i));
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("ovf_drained_empty", empty, 1);
    chk("ovf_sticky", overflow, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovf_cleared", overflow, 0);

    // Simultaneous push and pop while full.
    for (int i = 0; i < 16; i++) drive(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b0);
    chk("refill_full", full, 1);
    drive(1'b1, 8'hAA, 1'b0, 1'b1, 1'b0);
    chk("fullpp_level", level, 16);
    chk("fullpp_full", full, 1);
    chk("fullpp_ovf", overflow, 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("fullpp_pop%0d", i), out_data, (i == 15) ? 8'hAA : 8'h21 + 8'(i));
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("fullpp_empty", empty, 1);

    // Wrap-around against a reference queue with random gaps.
    for (int i = 0; i < 3; i++) begin
      logic [7:0] d = 8'($urandom_range(0, 255));
      drive(1'b1, d, 1'b0, 1'b0, 1'b0);
      q.push_back(d);
    end
    for (int i = 0; i < 40; i++) begin
      logic [7:0] d = 8'($urandom_range(0, 255));
      int gap = $urandom_range(0, 3);
      chk($sformatf("wrap_data%0d", i), out_data, q[0]);
      drive(1'b1, d, 1'b0, 1'b1, 1'b0);
      void'(q.pop_front());
      q.push_back(d);
      chk($sformatf("wrap_level%0d", i), level, 3);
      repeat (gap) idle();
    end
    while (q.size() > 0) begin
      chk("wrap_drain", out_data, q[0]);
      void'(q.pop_front());
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    chk("wrap_empty", empty, 1);
    chk("wrap_ovf", overflow, 0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
